mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one req/gnt/rvalid memory port between two requesters: the fetch stage (instruction port) and the load/store unit (data port).
- Picks one requester per cycle and forwards its request to memory.
- Records the owner of each granted transaction in an in-order tag FIFO, then routes each response (rdata/err/rvalid) back to its owner.
- Sits between the core and the unified memory/bus interface. Data has priority, with a starvation guard for fetch.

Parameters:
- MAX_OUTSTANDING, 2, number of granted-but-unanswered transactions allowed (matches fetch NUM_REQS); range 1..8.
- STARVE_LIMIT, 4, consecutive data grants while fetch waits before fetch is forced to win; range 1..15.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- instr_req_i  input  1  fetch request
- instr_addr_i  input  32  fetch address
- instr_gnt_o  output  1  fetch request accepted
- instr_rvalid_o  output  1  fetch response valid
- instr_rdata_o  output  32  fetch response data
- instr_err_o  output  1  fetch response error
- data_req_i  input  1  LSU request
- data_we_i  input  1  LSU write enable
- data_be_i  input  4  LSU byte enables
- data_addr_i  input  32  LSU address
- data_wdata_i  input  32  LSU write data
- data_gnt_o  output  1  LSU request accepted
- data_rvalid_o  output  1  LSU response valid
- data_rdata_o  output  32  LSU response data
- data_err_o  output  1  LSU response error
- mem_req_o  output  1  memory request
- mem_we_o  output  1  memory write enable (0 for fetch)
- mem_be_o  output  4  memory byte enables (4'hF for fetch)
- mem_addr_o  output  32  memory address
- mem_wdata_o  output  32  memory write data (0 for fetch)
- mem_gnt_i  input  1  memory accepted request
- mem_rvalid_i  input  1  memory response valid (in order)
- mem_rdata_i  input  32  memory response data
- mem_err_i  input  1  memory response error
- outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  count of unanswered transactions

Behaviour:
Reset:
- FSM enters ARB_IDLE; tag FIFO empty; outstanding_o=0; starvation counter 0.
- All req/gnt/rvalid outputs are 0. Data outputs are 0 on the unselected side.

Protocol:
- A requester holds req and its payload stable until gnt.
- Grant is combinational: instr_gnt_o = mem_gnt_i & sel_instr; data_gnt_o likewise for sel_data.
- A transaction occurs when mem_req_o & mem_gnt_i.

FSM states:
- ARB_IDLE:
  - No request is being held, so selection is free.
  - If full (outstanding == MAX_OUTSTANDING), mem_req_o=0.
  - Otherwise select data if data_req_i and not starved, else instr if instr_req_i.
  - Starved means counter == STARVE_LIMIT and instr_req_i=1.
  - If the selected request is granted this cycle, stay in ARB_IDLE. If not granted, go to ARB_INSTR or ARB_DATA.
- ARB_INSTR / ARB_DATA:
  - The selection is locked to that requester, and mem_req_o stays 1 even if the other side asserts req.
  - On mem_gnt_i, return to ARB_IDLE.
  - A locked state is never entered while full, so stability to memory is guaranteed.

Tag FIFO:
- Depth MAX_OUTSTANDING, 1-bit tag (0=instr, 1=data), circular pointers with wrap-around.
- Push on a transaction; pop on mem_rvalid_i.
- When full, no new mem_req_o is issued, even if mem_rvalid_i arrives in the same cycle. There is no combinational path from rvalid to req.
- Push and pop in the same cycle leave the count unchanged.

Response routing:
- Same cycle, combinational, from the FIFO head tag.
- The selected side gets rvalid/rdata/err. The other side gets rvalid=0, rdata=0, err=0.
- mem_rvalid_i while the FIFO is empty is dropped, and a simulation assertion fires.

Starvation counter (4-bit):
- Increment on a data transaction while instr_req_i=1.
- Clear on any instr transaction, or when instr_req_i=0. Saturates at STARVE_LIMIT.

Error handling:
- mem_err_i is forwarded with rvalid. It has no other effect.

Reset mid-transaction:
- All state clears immediately. Responses in flight afterwards are dropped as empty-FIFO rvalids.

Decomposition:
- Shared package core_bus_pkg: arb_state_e enum (ARB_IDLE, ARB_INSTR, ARB_DATA), tag constants TAG_INSTR/TAG_DATA, and a bus_req_t struct (we, be, addr, wdata).
- One sub-module, arb_tag_fifo: parameterised 1-bit in-order FIFO with push, pop, full, empty, count and head.

Test Plan:
- Both requesters assert in the same cycle, mem_gnt_i=1 -> data is granted first (mem_addr_o=data_addr_i, data_gnt_o=1); instr is granted next cycle; responses return tags 1 then 0.
- instr_req_i=1, mem_gnt_i held 0 for 3 cycles, data_req_i rises in cycle 2 -> mem_addr_o stays instr_addr_i throughout; the FSM stays in ARB_INSTR until gnt.
- MAX_OUTSTANDING=2, two grants with no rvalid -> outstanding_o=2 and mem_req_o=0. After one rvalid, outstanding_o=1 and mem_req_o reasserts on the next cycle.
- Continuous data_req_i and instr_req_i, STARVE_LIMIT=4, gnt always 1 -> 4 data grants, then 1 instr grant, repeating.
- Responses interleaved D,I,D with mem_err_i=1 on the second -> instr_err_o=1 only with instr_rvalid_o; rdata 0x11111111 and 0x33333333 reach the data side.
- rst pulsed high with 2 outstanding, then 2 rvalids -> both dropped, no rvalid output, outstanding_o stays 0.

Source files
------------

// File: rtl/core_bus_pkg.sv
// Shared types for the core-side memory bus: arbiter states, owner tags
// and the request payload carried from a requester to the memory port.
package core_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_INSTR = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_e;

    // Owner tag stored per granted transaction
    localparam logic TAG_INSTR = 1'b0;
    localparam logic TAG_DATA  = 1'b1;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order 1-bit owner-tag FIFO. One entry per granted transaction;
// the head entry tells which requester the next response belongs to.
module arb_tag_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic                           tag_i,
    input  logic                           pop_i,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           head_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] tags_q, tags_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Circular pointer advance; DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = tags_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        if (do_push) begin
            tags_d[wr_ptr_q] = tag_i;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tags_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            tags_q   <= tags_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between the fetch (instr) and
// LSU (data) requesters. Data wins by default; fetch is forced through
// after STARVE_LIMIT consecutive data grants while it waits. Responses
// are routed back in order using a tag FIFO.
module mem_port_arbiter
    import core_bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   instr_req_i,
    input  logic [31:0]                            instr_addr_i,
    output logic                                   instr_gnt_o,
    output logic                                   instr_rvalid_o,
    output logic [31:0]                            instr_rdata_o,
    output logic                                   instr_err_o,
    input  logic                                   data_req_i,
    input  logic                                   data_we_i,
    input  logic [3:0]                             data_be_i,
    input  logic [31:0]                            data_addr_i,
    input  logic [31:0]                            data_wdata_i,
    output logic                                   data_gnt_o,
    output logic                                   data_rvalid_o,
    output logic [31:0]                            data_rdata_o,
    output logic                                   data_err_o,
    output logic                                   mem_req_o,
    output logic                                   mem_we_o,
    output logic [3:0]                             mem_be_o,
    output logic [31:0]                            mem_addr_o,
    output logic [31:0]                            mem_wdata_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic [31:0]                            mem_rdata_i,
    input  logic                                   mem_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

    arb_state_e state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       sel_instr, sel_data;
    logic       starved;
    logic       txn, instr_txn, data_txn;
    logic       fifo_full, fifo_empty, fifo_head;
    logic       rsp_ok;
    bus_req_t   req_sel;

    // Fetch is starved once the guard counter saturates and it is still waiting
    assign starved = (starve_q == 4'(STARVE_LIMIT)) & instr_req_i;

    // Requester selection: free choice in IDLE, locked while a request is held
    always_comb begin
        sel_instr = 1'b0;
        sel_data  = 1'b0;
        case (state_q)
            ARB_INSTR: sel_instr = 1'b1;
            ARB_DATA:  sel_data  = 1'b1;
            default: begin
                if (!fifo_full) begin
                    if (data_req_i && !starved) begin
                        sel_data = 1'b1;
                    end else if (instr_req_i) begin
                        sel_instr = 1'b1;
                    end
                end
            end
        endcase
    end

    // Forward the selected requester's payload; fetch is a full-word read
    always_comb begin
        req_sel = '0;
        if (sel_data) begin
            req_sel.we    = data_we_i;
            req_sel.be    = data_be_i;
            req_sel.addr  = data_addr_i;
            req_sel.wdata = data_wdata_i;
        end else if (sel_instr) begin
            req_sel.we    = 1'b0;
            req_sel.be    = 4'hF;
            req_sel.addr  = instr_addr_i;
            req_sel.wdata = '0;
        end
    end

    assign mem_req_o   = sel_instr | sel_data;
    assign mem_we_o    = req_sel.we;
    assign mem_be_o    = req_sel.be;
    assign mem_addr_o  = req_sel.addr;
    assign mem_wdata_o = req_sel.wdata;

    assign instr_gnt_o = mem_gnt_i & sel_instr;
    assign data_gnt_o  = mem_gnt_i & sel_data;
    assign txn         = mem_req_o & mem_gnt_i;
    assign instr_txn   = instr_gnt_o;
    assign data_txn    = data_gnt_o;

    // Arbiter next state: lock onto an ungranted request until memory accepts it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (sel_data && !mem_gnt_i) begin
                    state_d = ARB_DATA;
                end else if (sel_instr && !mem_gnt_i) begin
                    state_d = ARB_INSTR;
                end
            end
            ARB_INSTR, ARB_DATA: begin
                if (mem_gnt_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Starvation guard: counts data wins while fetch waits, saturating
    always_comb begin
        starve_d = starve_q;
        if (!instr_req_i || instr_txn) begin
            starve_d = '0;
        end else if (data_txn && (starve_q != 4'(STARVE_LIMIT))) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Arbiter state and starvation counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (txn),
        .tag_i   (sel_data ? TAG_DATA : TAG_INSTR),
        .pop_i   (mem_rvalid_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o),
        .head_o  (fifo_head)
    );

    // A response with nothing outstanding has no owner and is dropped
    assign rsp_ok = mem_rvalid_i & ~fifo_empty;

    assign instr_rvalid_o = rsp_ok & (fifo_head == TAG_INSTR);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_rvalid_o  = rsp_ok & (fifo_head == TAG_DATA);
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    assign data_err_o     = data_rvalid_o & mem_err_i;

`ifndef SYNTHESIS
    // Flag ownerless responses (expected only after a mid-transaction reset)
    a_rvalid_owner: assert property (@(posedge clk) disable iff (rst)
        !(mem_rvalid_i && fifo_empty))
        else $warning("mem_port_arbiter: response with no outstanding transaction dropped");
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for single-cycle
// behaviour plus hand sequences for starvation and reset mid-transaction.
module tb_mem_port_arbiter;

    localparam logic [31:0] IA  = 32'h0000_1000;
    localparam logic [31:0] DA  = 32'h0000_2000;
    localparam logic [31:0] WD  = 32'hCAFE_0000;
    localparam logic [3:0]  DBE = 4'h3;

    logic        clk, rst;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [1:0]  outstanding_o;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .outstanding_o(outstanding_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // sel: 0 = no request, 1 = instr payload, 2 = data payload
    typedef struct {
        logic        ireq, dreq, gnt, rv, err;
        logic [31:0] rdata;
        int          sel;
        logic        igt, dgt, irv, drv;
        int          outst;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic ireq, input logic dreq, input logic gnt,
                                input logic rv, input logic [31:0] rdata, input logic err,
                                input int sel, input logic igt, input logic dgt,
                                input logic irv, input logic drv, input int outst);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.err = err;
        v.sel = sel; v.igt = igt; v.dgt = dgt; v.irv = irv; v.drv = drv; v.outst = outst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ireq, input logic dreq, input logic gnt,
                         input logic rv, input logic [31:0] rdata, input logic err);
        instr_req_i  = ireq;
        data_req_i   = dreq;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rdata;
        mem_err_i    = err;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        logic [31:0] e_addr, e_wdata;
        logic        e_we;
        logic [3:0]  e_be;
        e_addr  = (v.sel == 1) ? IA : (v.sel == 2) ? DA : 32'h0;
        e_wdata = (v.sel == 2) ? WD : 32'h0;
        e_we    = (v.sel == 2);
        e_be    = (v.sel == 1) ? 4'hF : (v.sel == 2) ? DBE : 4'h0;
        chk($sformatf("v%0d mem_req", i),    {31'b0, mem_req_o},      {31'b0, v.sel != 0});
        chk($sformatf("v%0d mem_addr", i),   mem_addr_o,              e_addr);
        chk($sformatf("v%0d mem_we", i),     {31'b0, mem_we_o},       {31'b0, e_we});
        chk($sformatf("v%0d mem_be", i),     {28'b0, mem_be_o},       {28'b0, e_be});
        chk($sformatf("v%0d mem_wdata", i),  mem_wdata_o,             e_wdata);
        chk($sformatf("v%0d instr_gnt", i),  {31'b0, instr_gnt_o},    {31'b0, v.igt});
        chk($sformatf("v%0d data_gnt", i),   {31'b0, data_gnt_o},     {31'b0, v.dgt});
        chk($sformatf("v%0d instr_rv", i),   {31'b0, instr_rvalid_o}, {31'b0, v.irv});
        chk($sformatf("v%0d instr_rdata", i), instr_rdata_o,          v.irv ? v.rdata : 32'h0);
        chk($sformatf("v%0d instr_err", i),  {31'b0, instr_err_o},    {31'b0, v.irv & v.err});
        chk($sformatf("v%0d data_rv", i),    {31'b0, data_rvalid_o},  {31'b0, v.drv});
        chk($sformatf("v%0d data_rdata", i), data_rdata_o,            v.drv ? v.rdata : 32'h0);
        chk($sformatf("v%0d data_err", i),   {31'b0, data_err_o},     {31'b0, v.drv & v.err});
        chk($sformatf("v%0d outstanding", i), {30'b0, outstanding_o}, 32'(v.outst));
    endtask

    initial begin
        // ireq dreq gnt rv rdata err | sel igt dgt irv drv outst
        // Both request: data first, then instr; responses tagged D then I
        vecs[0]  = mk(1, 1, 1, 0, 32'h0,         0, 2, 0, 1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 1, 0, 32'h0,         0, 1, 1, 0, 0, 0, 1);
        vecs[2]  = mk(0, 0, 0, 1, 32'hAAAA0001,  0, 0, 0, 0, 0, 1, 2);
        vecs[3]  = mk(0, 0, 0, 1, 32'hBBBB0002,  0, 0, 0, 0, 1, 0, 1);
        // Fetch held off by gnt=0 for 3 cycles; data arriving later cannot steal the port
        vecs[4]  = mk(1, 0, 0, 0, 32'h0,         0, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 32'h0,         0, 1, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 0, 0, 32'h0,         0, 1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 1, 1, 0, 32'h0,         0, 1, 1, 0, 0, 0, 0);
        vecs[8]  = mk(0, 1, 1, 0, 32'h0,         0, 2, 0, 1, 0, 0, 1);
        // Full: no request, even with rvalid in the same cycle; reissue next cycle
        vecs[9]  = mk(0, 1, 1, 0, 32'h0,         0, 0, 0, 0, 0, 0, 2);
        vecs[10] = mk(0, 1, 1, 1, 32'hCCCC0003,  0, 0, 0, 0, 1, 0, 2);
        vecs[11] = mk(0, 1, 1, 0, 32'h0,         0, 2, 0, 1, 0, 0, 1);
        vecs[12] = mk(0, 0, 0, 1, 32'hDDDD0004,  0, 0, 0, 0, 0, 1, 2);
        vecs[13] = mk(0, 0, 0, 1, 32'hEEEE0005,  0, 0, 0, 0, 0, 1, 1);
        // D, I, D responses with the error on the instr response
        vecs[14] = mk(0, 1, 1, 0, 32'h0,         0, 2, 0, 1, 0, 0, 0);
        vecs[15] = mk(1, 0, 1, 0, 32'h0,         0, 1, 1, 0, 0, 0, 1);
        vecs[16] = mk(0, 0, 0, 1, 32'h11111111,  0, 0, 0, 0, 0, 1, 2);
        vecs[17] = mk(0, 1, 1, 1, 32'h22222222,  1, 2, 0, 1, 1, 0, 1);
        vecs[18] = mk(0, 0, 0, 1, 32'h33333333,  0, 0, 0, 0, 0, 1, 1);

        instr_addr_i = IA;
        data_we_i    = 1'b1;
        data_be_i    = DBE;
        data_addr_i  = DA;
        data_wdata_i = WD;
        drive(0, 0, 0, 0, 32'h0, 0);
        rst = 1'b1;

        // Reset state
        #2;
        chk("rst mem_req",     {31'b0, mem_req_o},      32'h0);
        chk("rst instr_rv",    {31'b0, instr_rvalid_o}, 32'h0);
        chk("rst data_rv",     {31'b0, data_rvalid_o},  32'h0);
        chk("rst outstanding", {30'b0, outstanding_o},  32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].ireq, vecs[i].dreq, vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].err);
            #1;
            check_vec(i, vecs[i]);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 32'h0, 0);
        #1;
        chk("post-table outstanding", {30'b0, outstanding_o}, 32'h0);
        @(negedge clk);

        // Starvation: both always requesting, gnt always 1 -> D D D D I repeating.
        // rvalid each cycle after the first keeps one transaction outstanding.
        for (int c = 0; c < 15; c++) begin
            drive(1, 1, 1, (c != 0), 32'h5A5A0000 + 32'(c), 0);
            #1;
            chk($sformatf("starve c%0d data_gnt", c),  {31'b0, data_gnt_o},  {31'b0, (c % 5) != 4});
            chk($sformatf("starve c%0d instr_gnt", c), {31'b0, instr_gnt_o}, {31'b0, (c % 5) == 4});
            chk($sformatf("starve c%0d mem_addr", c),  mem_addr_o, ((c % 5) == 4) ? IA : DA);
            @(negedge clk);
        end
        drive(0, 0, 0, 1, 32'h0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0, 0);
        #1;
        chk("starve drained outstanding", {30'b0, outstanding_o}, 32'h0);
        @(negedge clk);

        // Reset mid-transaction: two outstanding, reset, then two stale responses
        drive(0, 1, 1, 0, 32'h0, 0);
        @(negedge clk);
        drive(1, 0, 1, 0, 32'h0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0, 0);
        #1;
        chk("pre-reset outstanding", {30'b0, outstanding_o}, 32'h2);
        rst = 1'b1;
        #1;
        chk("async reset outstanding", {30'b0, outstanding_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 1, 32'h77770000 + 32'(k), 0);
            #1;
            chk($sformatf("stale%0d instr_rv", k),    {31'b0, instr_rvalid_o}, 32'h0);
            chk($sformatf("stale%0d data_rv", k),     {31'b0, data_rvalid_o},  32'h0);
            chk($sformatf("stale%0d data_rdata", k),  data_rdata_o,            32'h0);
            chk($sformatf("stale%0d outstanding", k), {30'b0, outstanding_o},  32'h0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 32'h0, 0);
        #1;
        chk("final outstanding", {30'b0, outstanding_o}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
